// File: rtl/ram_program_loader.sv
// ram_program_loader: writes a host-supplied program image into the CPU RAM over the shared bus while holding the CPU
module ram_program_loader #(
    parameter int ADDR_W    = 4,
    parameter int RAM_BYTES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ack,
    output logic [7:0]      bus_out,
    output logic            bus_oe,
    output logic            nLma,
    output logic            nLmd,
    output logic            nLr,
    output logic            cpu_hold,
    output logic            done,
    output logic [ADDR_W:0] byte_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_VALID, S_CAPTURE, S_ADDR, S_DATA, S_WRITE, S_ACK, S_DONE
    } state_t;

    localparam logic [ADDR_W:0] L_LAST = (ADDR_W + 1)'(RAM_BYTES - 1);

    state_t          r_state, w_next;
    logic            r_load_m, r_load_s, r_valid_m, r_valid_s;
    logic [7:0]      r_data_q;
    logic [ADDR_W:0] r_count;
    logic            w_abort;

    assign w_abort    = !r_load_s && r_state != S_IDLE && r_state != S_DONE;
    assign byte_count = r_count;

    // two-flop synchronizers for the host strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_m  <= 1'b0;
            r_load_s  <= 1'b0;
            r_valid_m <= 1'b0;
            r_valid_s <= 1'b0;
        end else begin
            r_load_m  <= load_en;
            r_load_s  <= r_load_m;
            r_valid_m <= in_valid;
            r_valid_s <= r_valid_m;
        end
    end

    // state register; reset drops every strobe immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state: fixed walk through the write sequence, abort wins everywhere except IDLE/DONE
    always_comb begin
        w_next = r_state;
        if (w_abort) w_next = S_IDLE;
        else begin
            case (r_state)
                S_IDLE:       w_next = r_load_s ? S_WAIT_VALID : S_IDLE;
                S_WAIT_VALID: w_next = r_valid_s ? S_CAPTURE : S_WAIT_VALID;
                S_CAPTURE:    w_next = S_ADDR;
                S_ADDR:       w_next = S_DATA;
                S_DATA:       w_next = S_WRITE;
                S_WRITE:      w_next = S_ACK;
                S_ACK:        w_next = r_valid_s ? S_ACK : (r_count == L_LAST ? S_DONE : S_WAIT_VALID);
                S_DONE:       w_next = r_load_s ? S_DONE : S_IDLE;
                default:      w_next = S_IDLE;
            endcase
        end
    end

    // byte latch and write counter; the count only advances on a completed handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q <= 8'h00;
            r_count  <= '0;
        end else begin
            if (r_state == S_WAIT_VALID && r_valid_s) r_data_q <= in_data;
            if (w_abort || (r_state == S_IDLE && r_load_s)) r_count <= '0;
            else if (r_state == S_ACK && !r_valid_s) r_count <= r_count + 1'b1;
        end
    end

    // Moore output decode from the state register only
    always_comb begin
        in_ack   = r_state == S_ACK;
        bus_oe   = r_state == S_ADDR || r_state == S_DATA;
        bus_out  = r_state == S_ADDR ? 8'(r_count[ADDR_W-1:0]) : (r_state == S_DATA ? r_data_q : 8'h00);
        nLma     = r_state != S_ADDR;
        nLmd     = r_state != S_DATA;
        nLr      = r_state != S_WRITE;
        cpu_hold = r_state != S_IDLE && r_state != S_DONE;
        done     = r_state == S_DONE;
    end
endmodule

// File: tb/tb_ram_program_loader.sv
// tb_ram_program_loader: randomized handshake stimulus against a transaction-level RAM image model
module tb_ram_program_loader;
    localparam int RB = 16;

    logic       clk = 1'b0, rst_n = 1'b0, load_en = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ack, bus_oe, nLma, nLmd, nLr, cpu_hold, done;
    logic [7:0] bus_out;
    logic [4:0] byte_count;

    int         n_chk = 0, n_pass = 0, nlr_cnt = 0, m_count = 0, n0;
    bit         mon_en = 1'b0;
    logic [3:0] mar = 4'h0;
    logic [7:0] mdr = 8'h00;
    logic [7:0] ram [RB];
    logic [11:0] exp_q [$];
    logic [11:0] e;
    logic [6:0] a_lma, a_lmd, a_lr, a_ack, a_hold;
    logic [7:0] a_bus [7];

    always #5 clk = ~clk;

    ram_program_loader #(.ADDR_W(4), .RAM_BYTES(RB)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .in_data(in_data), .in_valid(in_valid),
        .in_ack(in_ack), .bus_out(bus_out), .bus_oe(bus_oe), .nLma(nLma), .nLmd(nLmd), .nLr(nLr),
        .cpu_hold(cpu_hold), .done(done), .byte_count(byte_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // CPU-side view: MAR/MDR/RAM updated by the strobes, every write matched against the expected queue
    always @(negedge clk) begin
        if (mon_en) begin
            chk("one_strobe", 32'($countones({!nLma, !nLmd, !nLr}) <= 1), 1);
            chk("oe_only_addr_data", 32'(bus_oe), 32'(!nLma || !nLmd));
            if (done) chk("done_releases_hold", 32'(cpu_hold), 0);
            if (!nLma) begin
                chk("mar_bus", 32'(bus_out), 32'(m_count));
                mar = bus_out[3:0];
            end
            if (!nLmd) mdr = bus_out;
            if (!nLr) begin
                nlr_cnt++;
                chk("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mar), 32'(e[11:8]));
                    chk("wr_data", 32'(mdr), 32'(e[7:0]));
                end
                ram[mar] = mdr;
            end
        end
    end

    task automatic start_load();
        load_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("load_hold", 32'(cpu_hold), 1);
        chk("load_count0", 32'(byte_count), 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input int hold);
        int t, w0;
        w0 = nlr_cnt;
        exp_q.push_back({m_count[3:0], d});
        in_data = d;
        in_valid = 1'b1;
        t = 0;
        while (in_ack !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        chk("ack_rise_latency", t, 7);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("ack_held", 32'(in_ack), 1);
        end
        in_valid = 1'b0;
        t = 0;
        while (in_ack !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        chk("ack_fall_latency", t, 3);
        m_count++;
        chk("byte_count", 32'(byte_count), m_count);
        chk("one_write", nlr_cnt - w0, 1);
    endtask

    task automatic send_early(input logic [7:0] d);
        int w0;
        bit seen;
        w0 = nlr_cnt;
        seen = 1'b0;
        exp_q.push_back({m_count[3:0], d});
        in_data = d;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (in_ack) seen = 1'b1;
        end
        chk("early_ack_pulse", 32'(seen), 1);
        m_count++;
        chk("early_byte_count", 32'(byte_count), m_count);
        chk("early_one_write", nlr_cnt - w0, 1);
    endtask

    initial begin
        load_en = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(in_ack), 0);
        chk("rst_oe", 32'(bus_oe), 0);
        chk("rst_bus", 32'(bus_out), 0);
        chk("rst_strobes", 32'({nLma, nLmd, nLr}), 32'h7);
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(byte_count), 0);
        load_en = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold", 32'(cpu_hold), 0);

        start_load();
        in_data = 8'hA5;
        in_valid = 1'b1;
        exp_q.push_back({4'h0, 8'hA5});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a_lma[i] = nLma; a_lmd[i] = nLmd; a_lr[i] = nLr; a_ack[i] = in_ack; a_bus[i] = bus_out;
        end
        chk("single_addr_strobe", 32'(a_lma[3]), 0);
        chk("single_addr_bus", 32'(a_bus[3]), 32'h00);
        chk("single_data_strobe", 32'(a_lmd[4]), 0);
        chk("single_data_bus", 32'(a_bus[4]), 32'hA5);
        chk("single_write_strobe", 32'(a_lr[5]), 0);
        chk("single_write_width", 32'({a_lr[4], a_lr[6]}), 32'h3);
        chk("single_ack_e5", 32'(a_ack[5]), 0);
        chk("single_ack_e6", 32'(a_ack[6]), 1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_ack[i] = in_ack;
        end
        chk("single_ack_e1", 32'(a_ack[1]), 1);
        chk("single_ack_e2", 32'(a_ack[2]), 0);
        m_count = 1;
        chk("single_count", 32'(byte_count), 1);
        chk("single_still_hold", 32'(cpu_hold), 1);

        send_byte(8'($urandom), 20);
        send_early(8'($urandom));
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), int'($urandom_range(0, 4)));
        load_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_wait_count", 32'(byte_count), 0);
        chk("abort_wait_hold", 32'(cpu_hold), 0);
        m_count = 0;

        start_load();
        for (int i = 0; i < RB; i++) begin
            if (i % 5 == 3) send_early(8'(8'h10 + i));
            else send_byte(8'(8'h10 + i), int'($urandom_range(0, 6)));
        end
        chk("full_done", 32'(done), 1);
        chk("full_hold", 32'(cpu_hold), 0);
        chk("full_count", 32'(byte_count), 16);
        for (int i = 0; i < RB; i++) chk($sformatf("ram_%0d", i), 32'(ram[i]), 32'(8'h10 + i));
        n0 = nlr_cnt;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("extra_no_ack", 32'(in_ack), 0);
        end
        in_valid = 1'b0;
        chk("extra_no_write", nlr_cnt, n0);
        chk("extra_count_sat", 32'(byte_count), 16);
        load_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("done_clear", 32'(done), 0);
        m_count = 0;

        start_load();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), int'($urandom_range(0, 3)));
        n0 = nlr_cnt;
        in_data = 8'($urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_lmd[i] = nLmd; a_lr[i] = nLr; a_hold[i] = cpu_hold;
            if (i == 2) load_en = 1'b0;
        end
        chk("abort_data_cycle", 32'(a_lmd[4]), 0);
        chk("abort_no_write_now", 32'(a_lr[5]), 1);
        chk("abort_hold", 32'(a_hold[5]), 0);
        chk("abort_count", 32'(byte_count), 0);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_write", nlr_cnt, n0);
        m_count = 0;

        start_load();
        send_byte(8'($urandom), 2);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
